// File: rtl/reg_file_param.sv
// Parametrised register file: one synchronous write port, two registered read ports.
// Define REG_FILE_PARAM_WRITE_BYPASS_EN for write-before-read on same-address same-edge access.
module reg_file_param #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [WIDTH-1:0]  rd0_data,
    output logic              rd0_valid,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [WIDTH-1:0]  rd1_data,
    output logic              rd1_valid,
    output logic              addr_err
);

    // One extra bit so DEPTH itself (up to 2**ADDR_W) is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_inr;
    logic             rd0_inr;
    logic             rd1_inr;
    logic             wr_ok;
    logic [WIDTH-1:0] rd0_word;
    logic [WIDTH-1:0] rd1_word;

    // Addresses are never wrapped: anything at or above DEPTH is an error.
    assign wr_inr  = {1'b0, wr_addr}  < DEPTH_L;
    assign rd0_inr = {1'b0, rd0_addr} < DEPTH_L;
    assign rd1_inr = {1'b0, rd1_addr} < DEPTH_L;
    assign wr_ok   = wr_en && wr_inr;

    // rdN_valid is a one-cycle tag: high after an edge where rdN_en was sampled high,
    // meaning rdN_data was reloaded (with 0 for an out-of-range address). No backpressure.
    always_comb begin
        rd0_word = '0;
        rd1_word = '0;
        if (rd0_inr) rd0_word = mem[rd0_addr];
        if (rd1_inr) rd1_word = mem[rd1_addr];
`ifdef REG_FILE_PARAM_WRITE_BYPASS_EN
        if (rd0_inr && wr_ok && (wr_addr == rd0_addr)) rd0_word = wr_data;
        if (rd1_inr && wr_ok && (wr_addr == rd1_addr)) rd1_word = wr_data;
`else
        // Read-before-write: same-edge reads see the old contents of mem.
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd0_data  <= '0;
            rd1_data  <= '0;
            rd0_valid <= 1'b0;
            rd1_valid <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            rd0_valid <= rd0_en;
            rd1_valid <= rd1_en;
            if (rd0_en) rd0_data <= rd0_word;
            if (rd1_en) rd1_data <= rd1_word;
            addr_err  <= (wr_en && !wr_inr) || (rd0_en && !rd0_inr) || (rd1_en && !rd1_inr);
        end
    end

endmodule
